// File: rtl/packet_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : packet_buffer_arbiter
// Description : Simple-dual-port packet buffer RAM with one write port and a
//               round-robin arbitrated read port shared by NUM_READERS
//               clients; each read returns a one-hot ready tag.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_buffer_arbiter #(
    parameter int NUM_READERS  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_READERS-1:0]                rd_req,
    input  logic [NUM_READERS*ADDR_WIDTH-1:0]     rd_addr,
    output logic [NUM_READERS-1:0]                rd_grant,
    output logic [NUM_READERS-1:0]                rd_ready,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic [$clog2(READ_LATENCY+1)-1:0]     rd_outstanding,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data
);

    localparam int c_IDX_W = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
    localparam int c_CNT_W = $clog2(READ_LATENCY + 1);
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [c_IDX_W-1:0]     r_last;
    logic [c_IDX_W-1:0]     w_gidx;
    logic [c_IDX_W-1:0]     w_idx;
    logic                   w_any;
    logic [NUM_READERS-1:0] w_grant;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic [c_CNT_W-1:0]     r_outstanding;

    logic [DATA_WIDTH-1:0]  r_mem       [c_DEPTH];
    logic [DATA_WIDTH-1:0]  r_data_pipe [READ_LATENCY];
    logic [NUM_READERS-1:0] r_tag_pipe  [READ_LATENCY];

    // Round-robin search starting one past the last granted client.
    always_comb begin
        w_grant = '0;
        w_gidx  = r_last;
        w_any   = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_READERS; k++) begin
            w_idx = c_IDX_W'((int'(r_last) + k) % NUM_READERS);
            if (!w_any && rd_req[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = w_idx;
            end
        end
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign rd_grant  = w_grant;
    assign w_rd_addr = rd_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= c_IDX_W'(NUM_READERS - 1);
        end else if (w_any) begin
            r_last <= w_gidx;
        end
    end

    // The array has no reset so it can map onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Stage 0 samples the RAM with non-blocking semantics, giving read-first behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_data_pipe[s] <= '0;
                r_tag_pipe[s]  <= '0;
            end
        end else begin
            r_data_pipe[0] <= r_mem[w_rd_addr];
            r_tag_pipe[0]  <= w_grant;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_data_pipe[s] <= r_data_pipe[s-1];
                r_tag_pipe[s]  <= r_tag_pipe[s-1];
            end
        end
    end

    assign rd_data  = r_data_pipe[READ_LATENCY-1];
    assign rd_ready = r_tag_pipe[READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_any, |rd_ready})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign rd_outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: doc/packet_buffer_arbiter.md
# packet_buffer_arbiter

Parametrised packet-buffer manager: a simple-dual-port inferred RAM with one write port and NUM_READERS read clients sharing the read port through a round-robin arbiter. Data width, depth, read latency and client count are parameters. Each read returns data with a per-client one-hot ready tag. Sits between the Ethernet RX/TX datapaths and the crypto engine, replacing single-client buffer access wherever several consumers read the same packet buffer.

## Interface
- NUM_READERS, 3: read clients; 1..8.
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 12: address bits; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 2: cycles from grant to data; >=1.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- rd_req  in  NUM_READERS  per-client read request; held until granted.
- rd_addr  in  NUM_READERS*ADDR_WIDTH  client i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_grant  out  NUM_READERS  one-hot or zero, combinational; request i accepted this cycle.
- rd_ready  out  NUM_READERS  one-hot or zero; rd_data valid for that client this cycle.
- rd_data  out  DATA_WIDTH  shared read data bus.
- rd_outstanding  out  $clog2(READ_LATENCY+1)  granted reads not yet returned.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.

## Operation
- Arbiter: registered pointer last (reset value NUM_READERS-1). Search rd_req starting at index last+1, wrapping modulo NUM_READERS; first set bit is granted. At most one grant per cycle. On a grant, last <= granted index; with no request, last holds.
- rd_grant depends only on rd_req and last; never asserted for a client whose rd_req is low.
- Granted address drives RAM read port; RAM output registered (stage 1), followed by READ_LATENCY-1 further data register stages.
- Tag pipeline: rd_grant vector shifted through READ_LATENCY registers; its output is rd_ready.
- rd_outstanding: +1 on grant, -1 when rd_ready nonzero, unchanged when both or neither.
- Write: when wr_en high, mem[wr_addr] <= wr_data at the edge. Writes never stall and never conflict with arbitration.
- Read-during-write, same address, same edge: read-first; the read returns the old word. A read granted the cycle after the write returns the new word.
- Addresses wrap naturally; no bounds checking.
- Reset asserted: rd_ready = 0, rd_data = 0, rd_outstanding = 0, last = NUM_READERS-1, tag and data pipelines cleared. In-flight reads are dropped and never produce rd_ready. RAM contents are not cleared.
- rd_grant during reset is combinational from rd_req; clients ignore it while reset is low.

## Timing
- Grant in cycle t (rd_req[i] & rd_grant[i] high at edge ending t) -> rd_ready[i] high and rd_data valid in cycle t+READ_LATENCY, for exactly one cycle.
- Throughput: one read per cycle sustained; data returns in grant order.
- With all NUM_READERS requesting continuously, each client is granted exactly once every NUM_READERS cycles. Maximum wait from rd_req rise to grant is NUM_READERS-1 cycles.
- First edge after reset deasserts: arbiter active. Reset release is synchronised by the top level.

## Test plan
- Single read, READ_LATENCY=2: write 0xA5 to 0x010; client 1 requests 0x010 in cycle t -> rd_grant=3'b010 in t, rd_ready=3'b010 and rd_data=0xA5 in t+2, rd_outstanding 1,1,0.
- Contention: clients 0,1,2 request together from reset and hold until granted -> grants 0,1,2 in consecutive cycles; rd_ready 001,010,100 two cycles later; data matches each address.
- Fairness: client 0 holds rd_req for 12 cycles while clients 1,2 re-request after each grant -> grant order 0,1,2 repeating; no client waits more than 2 cycles.
- Read-during-write: mem[0x020]=0x11; write 0x22 to 0x020 in cycle t with client 0 granted 0x020 in t -> returns 0x11; regrant in t+1 -> returns 0x22.
- Reset mid-flight: grant in t, reset low in t+1 -> rd_ready stays 0 through t+4; rd_outstanding=0; after release, next request is granted to client 0 first; RAM data preserved.
- Back-to-back with READ_LATENCY=1, NUM_READERS=1: 16 consecutive requests to 0..15 -> 16 consecutive rd_ready cycles, data in address order.
